manchester_encoder_tx: RTL and testbench
========================================

Name: manchester_encoder_tx

Overview:
- Transmit side of the Manchester link: takes payload bytes over an AXI-Stream-style slave and emits a framed, Manchester-encoded chip stream, two chips (one data bit) per aclk.
- Frame format: preamble bytes (0xAA), SFD (0xD5), payload bytes MSB-first, then an idle gap.
- Feeds the serializer/line driver; its output, captured at the far end, is what the receive-side decoder consumes.

Parameters:
- PREAMBLE_BYTES, 2, count of 0xAA bytes before the SFD (1..15).
- SFD_BYTE, 8'hD5, start-of-frame delimiter.
- GAP_CYCLES, 12, idle cycles forced after every frame or abort (>=1).
- IDLE_CHIPS, 2'b00, chip pair driven while not in a frame.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when tvalid&tready at a rising edge.
- s_axis_tlast  in  1  final payload byte of the frame.
- chips  out  2  chip pair for this cycle; chips[1] goes on the line first.
- chips_valid  out  1  high while chips carries frame content (preamble/SFD/data/CRC).
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  one-cycle pulse on frame abort.

Behaviour:
- Interface: one clock, aclk; reset synchronous, active-low, port aresetn.
- Encoding: data bit 1 -> chips 2'b01; bit 0 -> 2'b10. Bytes are sent MSB first.
- All outputs are registered.
- Reset values: chips=IDLE_CHIPS, chips_valid=0, busy=0, s_axis_tready=0, underrun=0.
- Reset also returns the FSM to IDLE, clears the bit and byte counters and the shift register, and truncates any frame in progress. No underrun pulse is generated by reset.
- FSM states: IDLE, PREAMBLE, SFD, DATA, (CRC), GAP.
- IDLE -> PREAMBLE: on the edge where s_axis_tvalid=1. The first preamble bit appears on chips in the following cycle. tready stays 0 in IDLE; the byte is not consumed yet.
- PREAMBLE: 8*PREAMBLE_BYTES bits of 0xAA, then -> SFD.
- SFD: 8 bits of SFD_BYTE, then -> DATA.
- tready generation: s_axis_tready=1 only in the cycle carrying bit 0 (the last bit) of the SFD or of the current data byte.
  - Handshake in that cycle: the byte is loaded and its MSB is on chips in the next cycle. There are no bubbles between bytes.
  - The last bit of a byte is the one that carried tlast=1: tready stays 0 and the next state is CRC if compiled in, else GAP.
- Underrun: tvalid=0 while tready=1 and the frame is not closed.
  - Next cycle: chips=IDLE_CHIPS, chips_valid=0, underrun=1 for one cycle, state -> GAP.
  - Truncated bits are not sent.
- GAP: GAP_CYCLES cycles of IDLE_CHIPS with chips_valid=0 and busy=1, then -> IDLE. tvalid is ignored in GAP.
- Input stability: tdata and tlast are sampled only at the handshake edge. tvalid may rise at any time; it is never dropped by the encoder.
- Frame length: throughput is exactly one bit per cycle. Frame length in cycles = 8*(PREAMBLE_BYTES+1+N) (+8 with CRC).
- A tlast on the very first byte gives a 1-byte frame. Zero-length frames are not possible.

Optional Feature:
- Macro: MANCHESTER_TX_CRC_EN.
- Defined: after the tlast byte, state CRC sends 8 bits of CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR).
  - Computed over payload bytes only, not preamble or SFD.
  - chips_valid=1 during CRC. The CRC register clears on entering PREAMBLE.
  - Underrun aborts before CRC; no CRC is sent.
- Undefined: no CRC state or logic; DATA goes directly to GAP after the tlast byte.

Test Plan:
- Reset check: hold aresetn=0 for 5 cycles -> chips=00, chips_valid=0, busy=0, tready=0, underrun=0.
- Basic frame: defaults, frame AA BB CC DD (tlast on DD), tvalid held high. Required response:
  - chips_valid high for exactly 56 consecutive cycles.
  - The concatenated chips equal the Manchester encoding of 56'hAAAAD5AABBCCDD (first pair 2'b01, 2'b10 on the first 0 bit).
  - tready pulses exactly 4 times, on cycles 24, 32, 40 and 48 of the frame.
- Back-to-back frames: two 1-byte frames (0x00, 0xFF), tvalid held high. Required response:
  - Exactly 12 idle cycles between frames.
  - The second frame starts with the preamble.
  - Data chips are 8x 2'b10, then 8x 2'b01.
- Underrun: frame 11 22 with tlast never asserted and tvalid dropped after 0x22. Required response:
  - underrun=1 for one cycle, immediately after the last bit of 0x22.
  - Then GAP, then IDLE; busy falls 12 cycles after the underrun pulse.
- Reset mid-frame: assert aresetn=0 during the DATA state for 1 cycle. Required response:
  - Next cycle chips=00, chips_valid=0, busy=0.
  - A new frame afterwards is bit-exact.
- With MANCHESTER_TX_CRC_EN: payload 0x31 32 33 34 35 36 37 38 39 ("123456789") -> trailing 8 data bits equal CRC 0xF4, chips_valid spans 8*(2+1+9+1)=104 cycles.

Source files
------------

// File: rtl/manchester_encoder_tx.sv
// ----------------------------------------------------------------------------
// manchester_encoder_tx
//
// Transmit side of the Manchester link. Payload bytes arrive on an
// AXI-Stream-style slave and leave as a framed, Manchester-encoded chip
// stream at one data bit (two chips) per aclk:
//
//   PREAMBLE_BYTES x 0xAA | SFD_BYTE | payload (MSB first) [| CRC-8] | gap
//
// Encoding: bit 1 -> chips 2'b01, bit 0 -> chips 2'b10; chips[1] is sent
// first on the line. Every output is registered.
//
// Optional feature: define MANCHESTER_TX_CRC_EN to append a CRC-8 byte
// (poly 0x07, init 0x00, MSB first, no reflection, no final XOR) that is
// computed over the payload bytes only.
//
// Ports:
//   aclk           in   clock
//   aresetn        in   synchronous active-low reset
//   s_axis_tdata   in   [7:0] payload byte
//   s_axis_tvalid  in   byte valid
//   s_axis_tready  out  byte taken when tvalid & tready at a rising edge
//   s_axis_tlast   in   final payload byte of the frame
//   chips          out  [1:0] chip pair for this cycle
//   chips_valid    out  chips carry frame content (preamble/SFD/data/CRC)
//   busy           out  FSM is not in IDLE
//   underrun       out  one-cycle pulse when a frame is aborted
// ----------------------------------------------------------------------------
module manchester_encoder_tx #(
    parameter int unsigned PREAMBLE_BYTES = 2,
    parameter logic [7:0]  SFD_BYTE       = 8'hD5,
    parameter int unsigned GAP_CYCLES     = 12,
    parameter logic [1:0]  IDLE_CHIPS     = 2'b00
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [1:0] chips,
    output logic       chips_valid,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       PRE_LAST = 4'(PREAMBLE_BYTES - 1);
    localparam logic [7:0]       PRE_BYTE = 8'hAA;

`ifdef MANCHESTER_TX_CRC_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_CRC, ST_GAP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_GAP
    } state_t;
`endif

    // state_q describes the bit currently on chips_q; the shift register's
    // MSB is that bit. Everything for the next cycle is derived from the
    // _d values, which keeps the outputs registered without extra latency.
    state_t           state_q,       state_d;
    logic [2:0]       bit_cnt_q,     bit_cnt_d;
    logic [3:0]       byte_cnt_q,    byte_cnt_d;
    logic [7:0]       shift_q,       shift_d;
    logic             last_q,        last_d;
    logic [GAP_W-1:0] gap_cnt_q,     gap_cnt_d;
    logic [1:0]       chips_q,       chips_d;
    logic             chips_valid_q, chips_valid_d;
    logic             busy_q,        busy_d;
    logic             tready_q,      tready_d;
    logic             underrun_q,    underrun_d;
    logic             in_frame_d;

`ifdef MANCHESTER_TX_CRC_EN
    logic [7:0]       crc_q,         crc_d;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        last_d     = last_q;
        gap_cnt_d  = gap_cnt_q;
        underrun_d = 1'b0;
`ifdef MANCHESTER_TX_CRC_EN
        crc_d      = crc_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // tvalid only starts the preamble; the byte is consumed at
                // the end of the SFD.
                if (s_axis_tvalid) begin
                    state_d    = ST_PREAMBLE;
                    shift_d    = PRE_BYTE;
                    bit_cnt_d  = 3'd7;
                    byte_cnt_d = '0;
`ifdef MANCHESTER_TX_CRC_EN
                    crc_d      = '0;
`endif
                end
            end

            ST_PREAMBLE: begin
                if (bit_cnt_q == 3'd0) begin
                    bit_cnt_d = 3'd7;
                    if (byte_cnt_q == PRE_LAST) begin
                        state_d = ST_SFD;
                        shift_d = SFD_BYTE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        shift_d    = PRE_BYTE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    shift_d   = {shift_q[6:0], 1'b0};
                end
            end

            ST_SFD, ST_DATA: begin
                if (bit_cnt_q != 3'd0) begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    shift_d   = {shift_q[6:0], 1'b0};
                end else if (state_q == ST_DATA && last_q) begin
                    // Frame closed by the tlast byte.
`ifdef MANCHESTER_TX_CRC_EN
                    state_d   = ST_CRC;
                    shift_d   = crc_q;
                    bit_cnt_d = 3'd7;
`else
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
`endif
                end else if (tready_q && s_axis_tvalid) begin
                    state_d   = ST_DATA;
                    shift_d   = s_axis_tdata;
                    last_d    = s_axis_tlast;
                    bit_cnt_d = 3'd7;
`ifdef MANCHESTER_TX_CRC_EN
                    crc_d     = crc8_byte(crc_q, s_axis_tdata);
`endif
                end else begin
                    // No byte at the handshake slot: abort the frame.
                    state_d    = ST_GAP;
                    gap_cnt_d  = GAP_LOAD;
                    underrun_d = 1'b1;
                end
            end

`ifdef MANCHESTER_TX_CRC_EN
            ST_CRC: begin
                if (bit_cnt_q == 3'd0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    shift_d   = {shift_q[6:0], 1'b0};
                end
            end
`endif

            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_frame_d    = (state_d != ST_IDLE) && (state_d != ST_GAP);
        chips_d       = in_frame_d ? (shift_d[7] ? 2'b01 : 2'b10) : IDLE_CHIPS;
        chips_valid_d = in_frame_d;
        busy_d        = (state_d != ST_IDLE);
        // Ready only on the last bit of the SFD or of a non-final data byte.
        tready_d      = (bit_cnt_d == 3'd0) &&
                        ((state_d == ST_SFD) || (state_d == ST_DATA && !last_d));
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            last_q        <= 1'b0;
            gap_cnt_q     <= '0;
            chips_q       <= IDLE_CHIPS;
            chips_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            tready_q      <= 1'b0;
            underrun_q    <= 1'b0;
`ifdef MANCHESTER_TX_CRC_EN
            crc_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            last_q        <= last_d;
            gap_cnt_q     <= gap_cnt_d;
            chips_q       <= chips_d;
            chips_valid_q <= chips_valid_d;
            busy_q        <= busy_d;
            tready_q      <= tready_d;
            underrun_q    <= underrun_d;
`ifdef MANCHESTER_TX_CRC_EN
            crc_q         <= crc_d;
`endif
        end
    end

    assign chips         = chips_q;
    assign chips_valid   = chips_valid_q;
    assign busy          = busy_q;
    assign s_axis_tready = tready_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_manchester_encoder_tx.sv
// ----------------------------------------------------------------------------
// tb_manchester_encoder_tx
//
// Self-checking bench for manchester_encoder_tx (default parameters). The
// expected chip stream is pushed to a queue whenever a byte is presented on
// the slave interface and popped whenever chips_valid is high. Per-cycle
// logs of the outputs are kept for frame-timing checks.
// Honours MANCHESTER_TX_CRC_EN when the RTL is built with it.
// ----------------------------------------------------------------------------
module tb_manchester_encoder_tx;

    localparam int PB  = 2;
    localparam int GAP = 12;
`ifdef MANCHESTER_TX_CRC_EN
    localparam int CRC_BITS = 8;
`else
    localparam int CRC_BITS = 0;
`endif

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tready;
    logic [1:0] chips;
    logic       chips_valid;
    logic       busy;
    logic       underrun;

    manchester_encoder_tx dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .chips         (chips),
        .chips_valid   (chips_valid),
        .busy          (busy),
        .underrun      (underrun)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    logic [7:0] payload[16];
    bit         tl[16];
    logic [7:0] model_crc;

    int         log_len;
    logic [1:0] log_chips[1024];
    logic       log_valid[1024];
    logic       log_ready[1024];
    logic       log_busy[1024];
    logic       log_under[1024];

`ifdef MANCHESTER_TX_CRC_EN
    function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in;
        for (int b = 7; b >= 0; b--) begin
            if (c[7] ^ d[b]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    task automatic push_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) exp_q.push_back(v[b] ? 2'b01 : 2'b10);
    endtask

    // Present payload[i] and push the chips it will produce.
    task automatic present(input int i);
        if (i == 0 || tl[i-1]) begin
            for (int p = 0; p < PB; p++) push_byte(8'hAA);
            push_byte(8'hD5);
            model_crc = 8'h00;
        end
        push_byte(payload[i]);
`ifdef MANCHESTER_TX_CRC_EN
        model_crc = crc8(model_crc, payload[i]);
        if (tl[i]) push_byte(model_crc);
`endif
        s_axis_tdata  = payload[i];
        s_axis_tlast  = tl[i];
        s_axis_tvalid = 1'b1;
    endtask

    // Stream payload[0..n-1]; tvalid stays high until every byte is taken.
    // rst_at >= 0 pulses aresetn for one edge after that cycle and returns.
    task automatic run_stream(input int n, input int budget, input int rst_at);
        bit hs;
        bit seen_busy;
        bit done;
        int idx;
        logic [1:0] e;
        idx = 0; done = 0; seen_busy = 0; log_len = 0;
        exp_q.delete();
        present(0);
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge aclk);
            log_chips[cyc] = chips;
            log_valid[cyc] = chips_valid;
            log_ready[cyc] = s_axis_tready;
            log_busy[cyc]  = busy;
            log_under[cyc] = underrun;
            log_len = cyc + 1;
            checks++;
            if (chips_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL chip_extra cyc=%0d got=%b required=none", cyc, chips);
                end else begin
                    e = exp_q.pop_front();
                    if (chips !== e) begin
                        errors++;
                        $display("FAIL chip cyc=%0d got=%b required=%b", cyc, chips, e);
                    end
                end
            end else if (chips !== 2'b00) begin
                errors++;
                $display("FAIL idle_chips cyc=%0d got=%b required=00", cyc, chips);
            end
            if (busy) seen_busy = 1;
            if (idx >= n && seen_busy && !busy) done = 1;
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            if (hs) begin
                idx++;
                if (idx < n) present(idx);
                else begin
                    s_axis_tvalid = 1'b0;
                    s_axis_tlast  = 1'b0;
                    s_axis_tdata  = '0;
                end
            end
            if (cyc == rst_at) begin
                aresetn = 1'b0;
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                @(posedge aclk);
                #1 aresetn = 1'b1;
                @(negedge aclk);
                checks++;
                if (chips !== 2'b00 || chips_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset chips=%b valid=%b busy=%b required 00/0/0",
                             chips, chips_valid, busy);
                end
                exp_q.delete();
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout budget=%0d idx=%0d", budget, idx);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL chips_missing got=%0d_left required=0", exp_q.size());
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (chips !== 2'b00 || chips_valid !== 1'b0 || busy !== 1'b0 ||
            s_axis_tready !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset chips=%b valid=%b busy=%b tready=%b underrun=%b required 00/0/0/0/0",
                     chips, chips_valid, busy, s_axis_tready, underrun);
        end
        @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic test_basic_frame;
        int first, lastv, nvalid, ntr, nund;
        bit contig;
        int trpos[8];
        int want[4];
        want[0] = 24; want[1] = 32; want[2] = 40; want[3] = 48;
        payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC; payload[3] = 8'hDD;
        tl[0] = 0; tl[1] = 0; tl[2] = 0; tl[3] = 1;
        run_stream(4, 400, -1);
        first = -1; lastv = -1; nvalid = 0; ntr = 0; nund = 0; contig = 1;
        for (int c = 0; c < log_len; c++) begin
            if (log_valid[c]) begin
                if (first < 0) first = c;
                else if (lastv != c - 1) contig = 0;
                lastv = c;
                nvalid++;
            end
            if (log_ready[c]) begin
                if (ntr < 8) trpos[ntr] = c - first + 1;
                ntr++;
            end
            if (log_under[c]) nund++;
        end
        checks++;
        if (nvalid != 56 + CRC_BITS || !contig) begin
            errors++;
            $display("FAIL basic_len got=%0d contig=%0d required=%0d contig=1",
                     nvalid, contig, 56 + CRC_BITS);
        end
        checks++;
        if (first < 0 || log_chips[first] !== 2'b01) begin
            errors++;
            $display("FAIL basic_first_pair got=%b required=01", (first < 0) ? 2'bxx : log_chips[first]);
        end
        checks++;
        if (ntr != 4) begin
            errors++;
            $display("FAIL basic_tready_count got=%0d required=4", ntr);
        end
        for (int k = 0; k < 4 && k < ntr; k++) begin
            checks++;
            if (trpos[k] != want[k]) begin
                errors++;
                $display("FAIL basic_tready_pos%0d got=%0d required=%0d", k, trpos[k], want[k]);
            end
        end
        checks++;
        if (nund != 0) begin
            errors++;
            $display("FAIL basic_underrun got=%0d required=0", nund);
        end
    endtask

    task automatic test_back_to_back;
        int s1, e1, s2, gap_len, gap_busy, nvalid;
        payload[0] = 8'h00; tl[0] = 1;
        payload[1] = 8'hFF; tl[1] = 1;
        run_stream(2, 400, -1);
        s1 = -1; e1 = -1; s2 = -1; nvalid = 0;
        for (int c = 0; c < log_len; c++) begin
            if (log_valid[c]) nvalid++;
            if (log_valid[c] && s1 < 0) s1 = c;
            if (s1 >= 0 && e1 < 0 && !log_valid[c]) e1 = c - 1;
            if (e1 >= 0 && s2 < 0 && log_valid[c]) s2 = c;
        end
        gap_len = 0; gap_busy = 0;
        if (e1 >= 0 && s2 > e1)
            for (int c = e1 + 1; c < s2; c++) begin
                gap_len++;
                if (log_busy[c]) gap_busy++;
            end
        checks++;
        if (s2 < 0 || gap_busy != GAP || gap_len != GAP + 1) begin
            errors++;
            $display("FAIL b2b_gap got=%0d_gap_cycles_%0d_total required=%0d_gap_cycles_%0d_total",
                     gap_busy, gap_len, GAP, GAP + 1);
        end
        checks++;
        if (nvalid != 2 * (32 + CRC_BITS)) begin
            errors++;
            $display("FAIL b2b_len got=%0d required=%0d", nvalid, 2 * (32 + CRC_BITS));
        end
        if (s2 >= 0) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (log_chips[s1 + 24 + k] !== 2'b10 || log_chips[s2 + 24 + k] !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_data bit%0d got=%b/%b required=10/01",
                             k, log_chips[s1 + 24 + k], log_chips[s2 + 24 + k]);
                end
            end
        end
    endtask

    task automatic test_underrun;
        int lastv, u, nund, fall, nvalid;
        payload[0] = 8'h11; tl[0] = 0;
        payload[1] = 8'h22; tl[1] = 0;
        run_stream(2, 400, -1);
        lastv = -1; u = -1; nund = 0; fall = -1; nvalid = 0;
        for (int c = 0; c < log_len; c++) begin
            if (log_valid[c]) begin lastv = c; nvalid++; end
            if (log_under[c]) begin nund++; u = c; end
            if (u >= 0 && fall < 0 && !log_busy[c]) fall = c;
        end
        checks++;
        if (nund != 1 || u != lastv + 1) begin
            errors++;
            $display("FAIL underrun_pulse got=%0d_pulses_at_%0d required=1_at_%0d", nund, u, lastv + 1);
        end
        checks++;
        if (nvalid != 40) begin
            errors++;
            $display("FAIL underrun_len got=%0d required=40", nvalid);
        end
        checks++;
        if (u < 0 || fall != u + GAP) begin
            errors++;
            $display("FAIL underrun_busy_fall got=%0d required=%0d", fall - u, GAP);
        end
    endtask

    task automatic test_reset_mid_frame;
        int nvalid;
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
        tl[0] = 0; tl[1] = 0; tl[2] = 0; tl[3] = 1;
        run_stream(4, 400, 35);
        payload[0] = 8'h5A; tl[0] = 0;
        payload[1] = 8'hC3; tl[1] = 1;
        run_stream(2, 400, -1);
        nvalid = 0;
        for (int c = 0; c < log_len; c++) if (log_valid[c]) nvalid++;
        checks++;
        if (nvalid != 40 + CRC_BITS) begin
            errors++;
            $display("FAIL post_reset_len got=%0d required=%0d", nvalid, 40 + CRC_BITS);
        end
    endtask

`ifdef MANCHESTER_TX_CRC_EN
    task automatic test_crc;
        int nvalid, lastv;
        logic [7:0] crc_exp;
        logic [7:0] got;
        crc_exp = 8'hF4;
        for (int i = 0; i < 9; i++) begin
            payload[i] = 8'h31 + 8'(i);
            tl[i] = (i == 8);
        end
        run_stream(9, 600, -1);
        nvalid = 0; lastv = -1;
        for (int c = 0; c < log_len; c++) if (log_valid[c]) begin nvalid++; lastv = c; end
        checks++;
        if (nvalid != 104) begin
            errors++;
            $display("FAIL crc_len got=%0d required=104", nvalid);
        end
        got = '0;
        if (lastv >= 7)
            for (int k = 0; k < 8; k++) got[7-k] = (log_chips[lastv - 7 + k] == 2'b01);
        checks++;
        if (got !== crc_exp) begin
            errors++;
            $display("FAIL crc_value got=%h required=%h", got, crc_exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
`ifdef MANCHESTER_TX_CRC_EN
        test_crc();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
